johnson_decoder: RTL and testbench

- Receive end for the twisted ring (Johnson) counter: samples a WIDTH-bit Johnson code and produces a registered binary index and a one-hot phase vector.
- Checks every sample for illegal codes and for breaks in the count sequence.
- Tracks lock state and keeps a saturating error count.
- Sits downstream of any twisted_ring_counter instance as its decoder and integrity monitor.

---
 rtl/johnson_decoder.sv | 135 +++++++++++++
 tb/tb_johnson_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// johnson_decoder: registered decoder and integrity monitor for a WIDTH-bit Johnson code stream.
// Define JOHNSON_DECODER_BIDIR_EN to also accept down-counting streams and add the dir output.
//
// state    | meaning
// UNLOCKED | fewer than LOCK_CNT consecutive correct steps since the last error
// LOCKED   | stream is following the sequence; any error returns to UNLOCKED
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int IW       = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   code_in,
  input  logic               in_valid,
  output logic               out_valid,
  output logic [IW-1:0]      index,
  output logic [2*WIDTH-1:0] onehot,
  output logic               illegal,
  output logic               seq_err,
  output logic               locked,
`ifdef JOHNSON_DECODER_BIDIR_EN
  output logic               dir,
`endif
  output logic [7:0]         err_count
);

  localparam int NS = 2*WIDTH;
  localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NS-1);
  localparam logic [NS-1:0]    OH_ONE   = NS'(1);
  localparam logic [3:0]       LOCK_TH  = 4'(LOCK_CNT);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t        state;
  logic          has_prev;
  logic [IW-1:0] last_idx;
  logic [3:0]    good_cnt;

  logic [WIDTH-1:0] inv;
  logic             code_legal;
  logic [IW-1:0]    dec_idx;
  logic [IW-1:0]    next_up;
  logic             good_step;
  logic             turn;
  logic [3:0]       cnt_step;
`ifdef JOHNSON_DECODER_BIDIR_EN
  logic [IW-1:0]    next_dn;
  logic             step_dn;
`endif

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // Legal codes are a run of ones anchored at bit 0, or a run of ones anchored at the MSB.
  always_comb begin
    inv        = ~code_in;
    code_legal = ((code_in & (code_in + CODE_ONE)) == '0) || ((inv & (inv + CODE_ONE)) == '0);
    if (code_in[WIDTH-1]) dec_idx = IW'(NS - popcount(code_in));
    else                  dec_idx = IW'(popcount(code_in));
    next_up = (last_idx == IDX_LAST) ? '0 : last_idx + IDX_ONE;
`ifdef JOHNSON_DECODER_BIDIR_EN
    next_dn   = (last_idx == '0) ? IDX_LAST : last_idx - IDX_ONE;
    step_dn   = (dec_idx == next_dn) && (dec_idx != next_up);
    good_step = (dec_idx == next_up) || step_dn;
    turn      = good_step && (step_dn != dir);
`else
    good_step = (dec_idx == next_up);
    turn      = 1'b0;
`endif
    cnt_step = turn ? 4'd1 : good_cnt + 4'd1;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      index     <= '0;
      onehot    <= '0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
      has_prev  <= 1'b0;
      last_idx  <= '0;
      good_cnt  <= '0;
      state     <= UNLOCKED;
`ifdef JOHNSON_DECODER_BIDIR_EN
      dir       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (!code_legal) begin
          illegal  <= 1'b1;
          seq_err  <= 1'b0;
          onehot   <= '0;
          good_cnt <= '0;
          state    <= UNLOCKED;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          illegal  <= 1'b0;
          index    <= dec_idx;
          onehot   <= OH_ONE << dec_idx;
          has_prev <= 1'b1;
          last_idx <= dec_idx;
          if (!has_prev) begin
            seq_err <= 1'b0;
          end else if (good_step && !(state == LOCKED && turn)) begin
            seq_err <= 1'b0;
`ifdef JOHNSON_DECODER_BIDIR_EN
            dir     <= step_dn;
`endif
            if (state == UNLOCKED) begin
              good_cnt <= cnt_step;
              if (cnt_step >= LOCK_TH) state <= LOCKED;
            end
          end else begin
            seq_err  <= 1'b1;
            good_cnt <= '0;
            state    <= UNLOCKED;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed scenarios plus randomized stream vs. a table-driven model.
// Honors JOHNSON_DECODER_BIDIR_EN when the design is built with it.
module tb_johnson_decoder;
  localparam int W  = 4;
  localparam int NS = 2*W;
  localparam int LC = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] code_in;
  logic         in_valid;
  logic         out_valid;
  logic [2:0]   index;
  logic [NS-1:0] onehot;
  logic         illegal, seq_err, locked;
  logic [7:0]   err_count;
`ifdef JOHNSON_DECODER_BIDIR_EN
  logic         dir;
`endif

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .in_valid(in_valid),
    .out_valid(out_valid), .index(index), .onehot(onehot), .illegal(illegal),
    .seq_err(seq_err), .locked(locked),
`ifdef JOHNSON_DECODER_BIDIR_EN
    .dir(dir),
`endif
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, n_fail = 0;

  // Code table built straight from the sequence definition.
  logic [W-1:0] tbl [NS];

  // Reference state
  int m_ov, m_idx, m_oh, m_ill, m_seq, m_lock, m_err, m_dir;
  int m_has, m_last, m_run;

  function automatic int lookup(input logic [W-1:0] c);
    for (int k = 0; k < NS; k++) if (tbl[k] == c) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_idx = 0; m_oh = 0; m_ill = 0; m_seq = 0; m_lock = 0; m_err = 0;
    m_dir = 0; m_has = 0; m_last = 0; m_run = 0;
  endtask

  task automatic model_err();
    m_seq = 1; m_run = 0; m_lock = 0;
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input logic [W-1:0] c, input logic v);
    int k;
    bit fwd, bwd, good, down;
    m_ov = int'(v);
    if (!v) return;
    k = lookup(c);
    if (k < 0) begin
      m_ill = 1; m_seq = 0; m_oh = 0; m_run = 0; m_lock = 0;
      if (m_err < 255) m_err++;
      return;
    end
    m_ill = 0; m_idx = k; m_oh = 1 << k;
    if (m_has == 0) begin
      m_seq = 0;
    end else begin
      fwd = (k == (m_last + 1) % NS);
`ifdef JOHNSON_DECODER_BIDIR_EN
      bwd = (k == (m_last + NS - 1) % NS);
`else
      bwd = 1'b0;
`endif
      good = fwd || bwd;
      down = bwd && !fwd;
      if (!good) model_err();
      else if (m_lock != 0 && int'(down) != m_dir) model_err();
      else begin
        m_seq = 0;
        if (m_lock == 0) begin
          m_run = (int'(down) != m_dir) ? 1 : m_run + 1;
          if (m_run >= LC) m_lock = 1;
        end
        m_dir = int'(down);
      end
    end
    m_has = 1; m_last = k;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".index"},     32'(index),     32'(m_idx));
    chk({tag, ".onehot"},    32'(onehot),    32'(m_oh));
    chk({tag, ".illegal"},   32'(illegal),   32'(m_ill));
    chk({tag, ".seq_err"},   32'(seq_err),   32'(m_seq));
    chk({tag, ".locked"},    32'(locked),    32'(m_lock));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
`ifdef JOHNSON_DECODER_BIDIR_EN
    chk({tag, ".dir"},       32'(dir),       32'(m_dir));
`endif
  endtask

  task automatic drive(input string tag, input logic [W-1:0] c, input logic v);
    @(negedge clk);
    code_in  = c;
    in_valid = v;
    model_step(c, v);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; code_in = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] seq9 [9];
    int n;
    for (int k = 0; k <= W; k++) tbl[k] = W'((1 << k) - 1);
    for (int k = W + 1; k < NS; k++) begin
      n = NS - k;
      tbl[k] = W'(((1 << n) - 1) << (W - n));
    end
    reset = 1'b0; in_valid = 1'b0; code_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    do_reset();

    // Full forward sequence with wrap.
    seq9 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      drive("fwd", seq9[i], 1'b1);
      if (i == 3) chk("lock_after_4th", 32'(locked), 32'd1);
    end
    chk("wrap_index", 32'(index), 32'd0);

    // Illegal while locked, then the true successor of the last legal index.
    drive("ill_locked", 4'b0101, 1'b1);
    chk("ill_drops_lock", 32'(locked), 32'd0);
    drive("after_ill", 4'b0001, 1'b1);
    chk("after_ill_seq", 32'(seq_err), 32'd0);

    // Jump while locked at index 2, then relock.
    do_reset();
    drive("pre2", 4'b1000, 1'b1);
    drive("pre2", 4'b0000, 1'b1);
    drive("pre2", 4'b0001, 1'b1);
    drive("pre2", 4'b0011, 1'b1);
    chk("locked_at2", 32'(locked), 32'd1);
    drive("jump", 4'b1110, 1'b1);
    chk("jump_seq", 32'(seq_err), 32'd1);
    chk("jump_idx", 32'(index), 32'd5);
    drive("relock", 4'b1100, 1'b1);
    drive("relock", 4'b1000, 1'b1);
    drive("relock", 4'b0000, 1'b1);
    chk("relocked", 32'(locked), 32'd1);
    drive("repeat", 4'b0000, 1'b1);
    chk("repeat_seq", 32'(seq_err), 32'd1);

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [W-1:0] c;
      logic v;
      r = int'($urandom_range(0, 99));
      if (r < 65)      c = tbl[(m_last + 1) % NS];
      else if (r < 75) c = tbl[(m_last + NS - 1) % NS];
      else if (r < 87) c = tbl[$urandom_range(0, NS - 1)];
      else             c = W'($urandom);
      v = ($urandom_range(0, 99) < 85);
      drive("rand", c, v);
    end

    // Error counter saturation with idle gaps.
    for (int i = 0; i < 300; i++) begin
      drive("sat", 4'b1010, 1'b1);
      if (i % 50 == 7) drive("gap", W'($urandom), 1'b0);
    end
    chk("err_sat", 32'(err_count), 32'd255);
    drive("gap_end", 4'b0001, 1'b0);
    chk("gap_hold", 32'(err_count), 32'd255);

    // Asynchronous reset mid-stream at index 6.
    do_reset();
    for (int k = 0; k <= 6; k++) drive("to6", tbl[k], 1'b1);
    chk("at6", 32'(index), 32'd6);
    #2;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    drive("post_rst", 4'b0111, 1'b1);
    chk("post_rst_idx", 32'(index), 32'd3);
    chk("post_rst_lock", 32'(locked), 32'd0);

`ifdef JOHNSON_DECODER_BIDIR_EN
    do_reset();
    drive("down", 4'b0111, 1'b1);
    drive("down", 4'b0011, 1'b1);
    drive("down", 4'b0001, 1'b1);
    drive("down", 4'b0000, 1'b1);
    chk("down_dir", 32'(dir), 32'd1);
    chk("down_lock", 32'(locked), 32'd1);
    drive("turn", 4'b0001, 1'b1);
    chk("turn_seq", 32'(seq_err), 32'd1);
    chk("turn_lock", 32'(locked), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
